// File: rtl/phv_queue_arbiter.sv
// Four per-queue PHV FIFOs merged round-robin into one registered valid/ready stream.
// Define PHV_ARB_QID_CHECK_EN to add the sticky qid_mismatch output.
module phv_queue_arbiter #(
  parameter int PHV_LEN    = 1024,
  parameter int NUM_QUEUES = 4,
  parameter int DEPTH_BITS = 2,
  parameter int QID_OFF    = 141
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PHV_LEN-1:0]    phv_in_0,
  input  logic [PHV_LEN-1:0]    phv_in_1,
  input  logic [PHV_LEN-1:0]    phv_in_2,
  input  logic [PHV_LEN-1:0]    phv_in_3,
  input  logic                  phv_in_valid_0,
  input  logic                  phv_in_valid_1,
  input  logic                  phv_in_valid_2,
  input  logic                  phv_in_valid_3,
  output logic                  phv_fifo_ready_0,
  output logic                  phv_fifo_ready_1,
  output logic                  phv_fifo_ready_2,
  output logic                  phv_fifo_ready_3,
  output logic [PHV_LEN-1:0]    phv_out,
  output logic                  phv_out_valid,
  input  logic                  phv_out_ready,
  output logic [NUM_QUEUES-1:0] phv_out_qid,
  output logic [NUM_QUEUES-1:0] q_overflow
`ifdef PHV_ARB_QID_CHECK_EN
  ,
  output logic [NUM_QUEUES-1:0] qid_mismatch
`endif
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CW    = DEPTH_BITS + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_NEAR = CW'(DEPTH - 1);

  typedef logic [PHV_LEN-1:0]    phv_t;
  typedef logic [DEPTH_BITS-1:0] ptr_t;
  typedef logic [CW-1:0]         cnt_t;
  typedef logic [1:0]            qidx_t;

  phv_t                  wr_data [NUM_QUEUES];
  phv_t                  mem     [NUM_QUEUES][DEPTH];
  ptr_t                  wr_ptr  [NUM_QUEUES];
  ptr_t                  rd_ptr  [NUM_QUEUES];
  cnt_t                  count   [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] wr_en;
  logic [NUM_QUEUES-1:0] accept;
  logic [NUM_QUEUES-1:0] pop;
  logic [NUM_QUEUES-1:0] full;
  logic [NUM_QUEUES-1:0] nonempty;
  logic [NUM_QUEUES-1:0] fifo_ready;
  logic [NUM_QUEUES-1:0] grant_onehot;
  qidx_t                 last_grant;
  qidx_t                 grant_idx;
  qidx_t                 cand;
  logic                  grant_found;
  logic                  load;
  phv_t                  head_data;

  assign wr_data[0] = phv_in_0;
  assign wr_data[1] = phv_in_1;
  assign wr_data[2] = phv_in_2;
  assign wr_data[3] = phv_in_3;
  assign wr_en      = {phv_in_valid_3, phv_in_valid_2, phv_in_valid_1, phv_in_valid_0};
  assign {phv_fifo_ready_3, phv_fifo_ready_2, phv_fifo_ready_1, phv_fifo_ready_0} = fifo_ready;

  always_comb begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      full[q]       = (count[q] == CNT_FULL);
      nonempty[q]   = (count[q] != '0);
      fifo_ready[q] = (count[q] < CNT_NEAR);
    end
  end

  // A full FIFO refuses the write even if it is being popped this cycle.
  assign accept = wr_en & ~full;

  // NOTE: every variable of a combinational block gets a default before any branch,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant;
    cand        = last_grant;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      cand = last_grant + qidx_t'(k);
      if (!grant_found && nonempty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign load         = (~phv_out_valid | phv_out_ready) & grant_found;
  assign grant_onehot = {{(NUM_QUEUES-1){1'b0}}, 1'b1} << grant_idx;
  assign pop          = load ? grant_onehot : '0;
  assign head_data    = mem[grant_idx][rd_ptr[grant_idx]];

  // NOTE: clocked state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        wr_ptr[q] <= '0;
        rd_ptr[q] <= '0;
        count[q]  <= '0;
      end
      q_overflow <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (accept[q]) wr_ptr[q] <= wr_ptr[q] + 1'b1;
        if (pop[q])    rd_ptr[q] <= rd_ptr[q] + 1'b1;
        if (accept[q] && !pop[q])      count[q] <= count[q] + 1'b1;
        else if (!accept[q] && pop[q]) count[q] <= count[q] - 1'b1;
        if (wr_en[q] && full[q]) q_overflow[q] <= 1'b1;
      end
    end
  end

  // NOTE: payload storage is deliberately not reset; the counts alone decide which
  // entries are live, so a reset flushes the FIFOs without touching the data array.
  always_ff @(posedge clk) begin
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (accept[q]) mem[q][wr_ptr[q]] <= wr_data[q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phv_out       <= '0;
      phv_out_valid <= 1'b0;
      phv_out_qid   <= '0;
      last_grant    <= 2'd3;
    end else if (load) begin
      phv_out       <= head_data;
      phv_out_valid <= 1'b1;
      phv_out_qid   <= grant_onehot;
      last_grant    <= grant_idx;
    end else if (phv_out_ready) begin
      phv_out_valid <= 1'b0;
    end
  end

`ifdef PHV_ARB_QID_CHECK_EN
  // The PHV is forwarded regardless; the flag only records that its QID bit disagreed.
  always_ff @(posedge clk) begin
    if (reset) begin
      qid_mismatch <= '0;
    end else begin
      for (int q = 0; q < NUM_QUEUES; q++) begin
        if (accept[q] && !wr_data[q][QID_OFF+q]) qid_mismatch[q] <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_phv_queue_arbiter.sv
// Scoreboard bench for phv_queue_arbiter: directed writes push expected PHVs, a monitor
// pops and compares on every accepted output beat.
module tb_phv_queue_arbiter;

  localparam int PHV_LEN = 1024;
  localparam int QID_OFF = 141;

  typedef logic [PHV_LEN-1:0] phv_t;
  typedef struct {
    logic [3:0] qid;
    phv_t       data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  phv_t       tb_in [4];
  logic [3:0] tb_vld = '0;
  logic       rdy = 1'b0;
  logic       phv_fifo_ready_0, phv_fifo_ready_1, phv_fifo_ready_2, phv_fifo_ready_3;
  phv_t       phv_out;
  logic       phv_out_valid;
  logic [3:0] phv_out_qid;
  logic [3:0] q_overflow;
`ifdef PHV_ARB_QID_CHECK_EN
  logic [3:0] qid_mismatch;
`endif

  int   n_vec  = 0;
  int   n_fail = 0;
  exp_t sb [$];

  phv_queue_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .phv_in_0        (tb_in[0]),
    .phv_in_1        (tb_in[1]),
    .phv_in_2        (tb_in[2]),
    .phv_in_3        (tb_in[3]),
    .phv_in_valid_0  (tb_vld[0]),
    .phv_in_valid_1  (tb_vld[1]),
    .phv_in_valid_2  (tb_vld[2]),
    .phv_in_valid_3  (tb_vld[3]),
    .phv_fifo_ready_0(phv_fifo_ready_0),
    .phv_fifo_ready_1(phv_fifo_ready_1),
    .phv_fifo_ready_2(phv_fifo_ready_2),
    .phv_fifo_ready_3(phv_fifo_ready_3),
    .phv_out         (phv_out),
    .phv_out_valid   (phv_out_valid),
    .phv_out_ready   (rdy),
    .phv_out_qid     (phv_out_qid),
    .q_overflow      (q_overflow)
`ifdef PHV_ARB_QID_CHECK_EN
   ,.qid_mismatch    (qid_mismatch)
`endif
  );

  always #5 clk = ~clk;

  function automatic phv_t make_phv(int id, logic [3:0] qid_field);
    phv_t d;
    for (int w = 0; w < PHV_LEN / 32; w++) d[w*32 +: 32] = 32'hC0DE0000 ^ 32'(id) ^ 32'(w << 8);
    d[QID_OFF +: 4] = qid_field;
    return d;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic check_phv(string name, phv_t act, phv_t exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got low128 %h, want low128 %h", name, act[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [3:0] readies();
    return {phv_fifo_ready_3, phv_fifo_ready_2, phv_fifo_ready_1, phv_fifo_ready_0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    tb_vld = '0;
  endtask

  task automatic put(int q, int id, logic [3:0] qid_field);
    tb_in[q]  = make_phv(id, qid_field);
    tb_vld[q] = 1'b1;
  endtask

  task automatic expect_out(int q, int id, logic [3:0] qid_field);
    exp_t e;
    e.qid  = 4'(1 << q);
    e.data = make_phv(id, qid_field);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic drain(string name);
    logic done = 1'b0;
    rdy = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !phv_out_valid) done = 1'b1;
    end
    check(name, 64'(done), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && phv_out_valid && rdy) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_beat: got qid %b, want no output", phv_out_qid);
        end else begin
          e = sb.pop_front();
          check("out_qid", 64'(phv_out_qid), 64'(e.qid));
          check_phv("out_data", phv_out, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int q = 0; q < 4; q++) tb_in[q] = '0;

    // Reset state and single-PHV latency.
    rdy = 1'b1;
    do_reset();
    check("rst_valid", 64'(phv_out_valid), 64'd0);
    check("rst_qid", 64'(phv_out_qid), 64'd0);
    check_phv("rst_data", phv_out, '0);
    check("rst_ovf", 64'(q_overflow), 64'd0);
    check("rst_ready", 64'(readies()), 64'hf);
    expect_out(0, 1, 4'b0001);
    put(0, 1, 4'b0001);
    step();
    @(negedge clk); check("lat_t1", 64'(phv_out_valid), 64'd0);
    @(negedge clk); check("lat_t2", 64'(phv_out_valid), 64'd1);
    @(negedge clk); check("lat_t3", 64'(phv_out_valid), 64'd0);
    @(posedge clk); #1;

    // Round-robin order with two PHVs preloaded on every queue.
    rdy = 1'b0;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int q = 0; q < 4; q++) begin
        put(q, 10 + r * 4 + q, 4'(1 << q));
        expect_out(q, 10 + r * 4 + q, 4'(1 << q));
      end
      step();
    end
    step();
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); check("rr_valid", 64'(phv_out_valid), 64'd1);
      @(posedge clk); #1;
    end
    @(negedge clk); check("rr_end", 64'(phv_out_valid), 64'd0);
    @(posedge clk); #1;

    // Queue 2 fill, nearly-full flag and overflow drop behind a held output.
    rdy = 1'b0;
    expect_out(0, 19, 4'b0001);
    put(0, 19, 4'b0001);
    step();
    for (int i = 0; i < 5; i++) begin
      put(2, 20 + i, 4'b0100);
      if (i < 4) expect_out(2, 20 + i, 4'b0100);
      step();
      if (i < 2) check("fill_ready", 64'(phv_fifo_ready_2), 64'd1);
      else       check("fill_ready", 64'(phv_fifo_ready_2), 64'd0);
      if (i < 4) check("fill_ovf", 64'(q_overflow), 64'd0);
      else       check("fill_ovf", 64'(q_overflow), 64'b0100);
    end
    drain("drain_fill");

    // Output held for five cycles while queues 1 and 3 fill; then RR continues from 0.
    rdy = 1'b0;
    expect_out(0, 30, 4'b0001);
    put(0, 30, 4'b0001);
    step();
    @(posedge clk); #1;
    expect_out(1, 31, 4'b0010);
    expect_out(3, 32, 4'b1000);
    expect_out(1, 33, 4'b0010);
    expect_out(3, 34, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      if (i < 2) begin
        put(1, 31 + 2 * i, 4'b0010);
        put(3, 32 + 2 * i, 4'b1000);
      end
      @(negedge clk);
      check("hold_valid", 64'(phv_out_valid), 64'd1);
      check("hold_qid", 64'(phv_out_qid), 64'b0001);
      check_phv("hold_data", phv_out, make_phv(30, 4'b0001));
      step();
    end
    drain("drain_hold");

    // Reset with an output held and three PHVs buffered flushes everything.
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(1, 40 + i, 4'b0010);
      step();
    end
    check("pre_rst_valid", 64'(phv_out_valid), 64'd1);
    check("pre_rst_ready1", 64'(phv_fifo_ready_1), 64'd0);
    check("pre_rst_ovf", 64'(q_overflow), 64'b0100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_valid", 64'(phv_out_valid), 64'd0);
    check("mid_rst_ready", 64'(readies()), 64'hf);
    check("mid_rst_ovf", 64'(q_overflow), 64'd0);
    rdy = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(phv_out_valid), 64'd0);

`ifdef PHV_ARB_QID_CHECK_EN
    // Wrong QID bits on queue 3: flagged but forwarded unchanged.
    check("qm_clear", 64'(qid_mismatch), 64'd0);
    expect_out(3, 50, 4'b0001);
    put(3, 50, 4'b0001);
    step();
    check("qm_set", 64'(qid_mismatch), 64'b1000);
    drain("drain_qm");
`endif

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
